// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - per-channel interrupt FIFOs feeding a held, acknowledged instruction output
// Round-robin by default; define INTERRUPT_ARBITER_FIXED_PRIO_EN for strict lowest-index priority.
module interrupt_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_instr,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     int_ack,
  output logic [DATA_W-1:0]        interrupt_instruction,
  output logic                     int_pending,
  output logic [GW-1:0]            grant_ch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [CW-1:0]     count  [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [GW-1:0]     start;
  logic [GW-1:0]     sel;
  logic [GW-1:0]     sel_next;
  logic              found;
  logic              arb_take;
  int                idx;

`ifdef INTERRUPT_ARBITER_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [GW-1:0] rr_ptr;
  assign start = rr_ptr;
`endif

  // Zero words complete the handshake but are dropped: 0 means "no interrupt".
  always_comb begin
    ch_ready = '0;
    push     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = (count[i] != CW'(FIFO_DEPTH));
      push[i]     = ch_valid[i] && ch_ready[i] && (ch_instr[i*DATA_W +: DATA_W] != '0);
    end
  end

  // Search uses registered counts only, so a same-edge push is never seen.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = int'(start) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && (count[idx] != '0)) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  assign arb_take = found && ((state == IDLE) || int_ack);
  assign sel_next = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++)
      pop[i] = arb_take && (sel == GW'(i));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read when count marks them valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= ch_instr[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      interrupt_instruction <= '0;
      int_pending           <= 1'b0;
      grant_ch              <= '0;
`ifndef INTERRUPT_ARBITER_FIXED_PRIO_EN
      rr_ptr                <= '0;
`endif
    end else begin
      case (state)
        IDLE, PRESENT: begin
          if (arb_take) begin
            interrupt_instruction <= mem[sel][rd_ptr[sel]];
            grant_ch              <= sel;
            int_pending           <= 1'b1;
            state                 <= PRESENT;
`ifndef INTERRUPT_ARBITER_FIXED_PRIO_EN
            rr_ptr                <= sel_next;
`endif
          end else if (state == PRESENT && int_ack) begin
            interrupt_instruction <= '0;
            int_pending           <= 1'b0;
            state                 <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
